// File: rtl/gate_request_queue_if.sv
// Request/command bundle between the gate terminals, this queue and the
// parking controller. The slave modport is the queue's view of the bundle.
interface gate_request_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Gate terminal side
  logic [15:0]   req_plate;
  logic          req_in;
  logic          req_out;
  logic          leak_req;
  logic [2:0]    leak_floor_req;
  // Controller side
  logic          ctrl_busy;
  logic [15:0]   license_plate;
  logic          in_mode;
  logic          out_mode;
  logic          leakage;
  logic [2:0]    leakage_floor;
  // Queue status
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          reject;

  modport slave (
    input  req_plate, req_in, req_out, leak_req, leak_floor_req, ctrl_busy,
    output license_plate, in_mode, out_mode, leakage, leakage_floor,
           count, full, empty, overflow, reject
  );

  modport master (
    output req_plate, req_in, req_out, leak_req, leak_floor_req, ctrl_busy,
    input  license_plate, in_mode, out_mode, leakage, leakage_floor,
           count, full, empty, overflow, reject
  );
endinterface

// File: rtl/gate_request_queue.sv
// Gate request queue: validates entry/exit requests, buffers them in a small
// FIFO and issues them one at a time to the parking controller while it is
// idle. Leakage alarms are registered straight through and hold off issue.
module gate_request_queue #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 2
) (
  input  logic clock,
  input  logic reset,
  gate_request_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLDOFF) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q, cnt_next;
  logic          full_q, empty_q, overflow_q, reject_q;
  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic [15:0]   plate_q;
  logic          in_mode_q, out_mode_q;
  logic          leak_q;
  logic [2:0]    floor_q;

  logic          digits_ok, valid, malformed, push, pop;
  logic [16:0]   head;

  assign head = mem[rd_ptr];

  // Classify the incoming request and decide this cycle's push/pop.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_plate[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    valid     = (bus.req_in ^ bus.req_out) && digits_ok;
    malformed = (bus.req_in && bus.req_out) ||
                ((bus.req_in || bus.req_out) && !digits_ok);
    pop       = (state == S_IDLE) && !empty_q && !bus.ctrl_busy && !bus.leak_req;
    // A full FIFO still accepts when the head leaves on the same edge.
    push      = valid && (!full_q || pop);
    cnt_next  = cnt_q + CW'(push) - CW'(pop);
  end

  // Storage array: written on accepted pushes only.
  // NOTE: the data array has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {bus.req_in, bus.req_plate};
  end

  // Pointers, occupancy and the one-cycle error pulses.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt_q      <= cnt_next;
      full_q     <= (cnt_next == CW'(DEPTH));
      empty_q    <= (cnt_next == '0);
      overflow_q <= valid && !push;
      reject_q   <= malformed;
    end
  end

  // Issue sequencer: one-cycle command pulse, then hold until the controller settles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      plate_q    <= '0;
      in_mode_q  <= 1'b0;
      out_mode_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state      <= S_ISSUE;
            plate_q    <= head[15:0];
            in_mode_q  <= head[16];
            out_mode_q <= !head[16];
          end
        end
        S_ISSUE: begin
          state      <= S_HOLD;
          hold_cnt   <= HW'(HOLDOFF - 1);
          in_mode_q  <= 1'b0;
          out_mode_q <= 1'b0;
        end
        S_HOLD: begin
          if (hold_cnt == '0) begin
            if (!bus.ctrl_busy) begin
              state   <= S_IDLE;
              plate_q <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state      <= S_IDLE;
          plate_q    <= '0;
          in_mode_q  <= 1'b0;
          out_mode_q <= 1'b0;
        end
      endcase
    end
  end

  // Leakage alarm bypass: one-cycle registered copy, floor forced to 0 when quiet.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      leak_q  <= 1'b0;
      floor_q <= '0;
    end else begin
      leak_q  <= bus.leak_req;
      floor_q <= bus.leak_req ? bus.leak_floor_req : 3'd0;
    end
  end

  assign bus.license_plate = plate_q;
  assign bus.in_mode       = in_mode_q;
  assign bus.out_mode      = out_mode_q;
  assign bus.leakage       = leak_q;
  assign bus.leakage_floor = floor_q;
  assign bus.count         = cnt_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.overflow      = overflow_q;
  assign bus.reject        = reject_q;
endmodule

// File: tb/tb_gate_request_queue.sv
// Bench for gate_request_queue: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level queue model.
module tb_gate_request_queue;
  localparam int DEPTH   = 4;
  localparam int HOLDOFF = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  gate_request_queue_if #(.DEPTH(DEPTH)) bus ();

  gate_request_queue #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of {dir, plate} plus the time since the last issue.
  logic [16:0] mq[$];
  logic        m_eng;
  int          m_age;
  logic [15:0] m_plate;
  logic        m_in, m_out, m_leak, m_ovf, m_rej;
  logic [2:0]  m_floor;
  logic [15:0] issued[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bcd_ok(input logic [15:0] p);
    for (int i = 0; i < 4; i++) if (p[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_eng = 0; m_age = 0; m_plate = '0; m_in = 0; m_out = 0;
    m_leak = 0; m_floor = '0; m_ovf = 0; m_rej = 0;
  endtask

  task automatic model_step();
    logic v, mal, popped, ok;
    int   size_before;
    logic [16:0] h;
    if (!reset) begin model_reset(); return; end
    ok  = bcd_ok(bus.req_plate);
    v   = (bus.req_in != bus.req_out) && ok;
    mal = (bus.req_in && bus.req_out) || ((bus.req_in || bus.req_out) && !ok);
    size_before = mq.size();
    popped = 0;
    if (m_eng) begin
      m_in = 0; m_out = 0;
      if (m_age >= HOLDOFF && !bus.ctrl_busy) begin m_eng = 0; m_plate = '0; end
      else m_age++;
    end else if (mq.size() > 0 && !bus.ctrl_busy && !bus.leak_req) begin
      h = mq.pop_front();
      popped = 1; m_eng = 1; m_age = 0;
      m_plate = h[15:0]; m_in = h[16]; m_out = !h[16];
    end else begin
      m_in = 0; m_out = 0;
    end
    m_ovf = 0;
    if (v) begin
      if (size_before < DEPTH || popped) mq.push_back({bus.req_in, bus.req_plate});
      else m_ovf = 1;
    end
    m_rej   = mal;
    m_leak  = bus.leak_req;
    m_floor = bus.leak_req ? bus.leak_floor_req : 3'd0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_plate"}, 32'(bus.license_plate), 32'(m_plate));
    check({tag, "_in"},    32'(bus.in_mode),       32'(m_in));
    check({tag, "_out"},   32'(bus.out_mode),      32'(m_out));
    check({tag, "_leak"},  32'(bus.leakage),       32'(m_leak));
    check({tag, "_floor"}, 32'(bus.leakage_floor), 32'(m_floor));
    check({tag, "_count"}, 32'(bus.count),         32'(mq.size()));
    check({tag, "_full"},  32'(bus.full),          32'(mq.size() == DEPTH));
    check({tag, "_empty"}, 32'(bus.empty),         32'(mq.size() == 0));
    check({tag, "_ovf"},   32'(bus.overflow),      32'(m_ovf));
    check({tag, "_rej"},   32'(bus.reject),        32'(m_rej));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clock);
    #1;
    compare_all(tag);
    if (bus.in_mode || bus.out_mode) issued.push_back(bus.license_plate);
  endtask

  task automatic cyc(input string tag, input logic ri, input logic ro, input logic [15:0] p,
                     input logic busy, input logic lk, input logic [2:0] fl);
    bus.req_in = ri; bus.req_out = ro; bus.req_plate = p;
    bus.ctrl_busy = busy; bus.leak_req = lk; bus.leak_floor_req = fl;
    tick(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic busy);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 16'h0, busy, 0, 3'd0);
  endtask

  initial begin
    logic [15:0] s2_plates [5];
    logic [15:0] p;
    logic        busy_r, lk_r;
    s2_plates = '{16'h9423, 16'h8754, 16'h9706, 16'h2666, 16'h7723};
    bus.req_in = 0; bus.req_out = 0; bus.req_plate = '0;
    bus.ctrl_busy = 0; bus.leak_req = 0; bus.leak_floor_req = '0;
    model_reset();

    // Reset state
    repeat (3) tick("rst");
    reset = 1'b1;
    idle("post_rst", 2, 0);

    // Single entry issued with minimum latency
    cyc("s1_req", 1, 0, 16'h9423, 0, 0, 3'd0);
    cyc("s1_issue", 0, 0, 16'h0, 0, 0, 3'd0);
    check("s1_in_mode", 32'(bus.in_mode), 32'd1);
    check("s1_plate", 32'(bus.license_plate), 32'h9423);
    check("s1_count", 32'(bus.count), 32'd0);
    idle("s1_tail", 5, 0);

    // Five entries while busy: four queue, fifth overflows, then in-order issue
    issued.delete();
    for (int i = 0; i < 5; i++) begin
      cyc("s2_fill", 1, 0, s2_plates[i], 1, 0, 3'd0);
      if (i == 3) check("s2_full", 32'(bus.full), 32'd1);
    end
    check("s2_overflow", 32'(bus.overflow), 32'd1);
    idle("s2_drain", 24, 0);
    check("s2_issued_n", 32'(issued.size()), 32'd4);
    for (int i = 0; i < 4 && i < issued.size(); i++)
      check($sformatf("s2_order%0d", i), 32'(issued[i]), 32'(s2_plates[i]));

    // Malformed requests
    cyc("s3_both", 1, 1, 16'h1234, 0, 0, 3'd0);
    check("s3_rej1", 32'(bus.reject), 32'd1);
    cyc("s3_digit", 1, 0, 16'h9A23, 0, 0, 3'd0);
    check("s3_rej2", 32'(bus.reject), 32'd1);
    check("s3_count", 32'(bus.count), 32'd0);
    idle("s3_tail", 3, 0);

    // Leakage holds off issue; exit issues once the alarm clears
    issued.delete();
    cyc("s4_leak", 0, 1, 16'h8754, 0, 1, 3'd1);
    for (int i = 0; i < 6; i++) cyc("s4_leak", 0, 0, 16'h0, 0, 1, 3'd1);
    check("s4_floor", 32'(bus.leakage_floor), 32'd1);
    check("s4_held", 32'(issued.size()), 32'd0);
    idle("s4_release", 3, 0);
    check("s4_issued", 32'(issued.size() > 0 ? issued[0] : 16'h0), 32'h8754);
    idle("s4_tail", 6, 0);

    // Full FIFO with simultaneous push and pop
    cyc("s5_fill", 1, 0, 16'h1111, 1, 0, 3'd0);
    cyc("s5_fill", 0, 1, 16'h2222, 1, 0, 3'd0);
    cyc("s5_fill", 1, 0, 16'h3333, 1, 0, 3'd0);
    cyc("s5_fill", 0, 1, 16'h4444, 1, 0, 3'd0);
    cyc("s5_pushpop", 1, 0, 16'h5555, 0, 0, 3'd0);
    check("s5_count", 32'(bus.count), 32'd4);
    check("s5_no_ovf", 32'(bus.overflow), 32'd0);
    idle("s5_drain", 24, 0);

    // Asynchronous reset in HOLD with two entries queued
    cyc("s6_a", 1, 0, 16'h1234, 0, 0, 3'd0);
    cyc("s6_b", 0, 1, 16'h4321, 0, 0, 3'd0);
    cyc("s6_c", 1, 0, 16'h5678, 1, 0, 3'd0);
    cyc("s6_hold", 0, 0, 16'h0, 1, 0, 3'd0);
    check("s6_count", 32'(bus.count), 32'd2);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("s6_async");
    idle("s6_inrst", 2, 0);
    #1 reset = 1'b1;
    issued.delete();
    idle("s6_after", 8, 0);
    check("s6_no_issue", 32'(issued.size()), 32'd0);

    // Random traffic against the model
    busy_r = 0; lk_r = 0;
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 4; d++)
        p[4*d +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) busy_r = !busy_r;
      if ($urandom_range(0, 19) == 0) lk_r = !lk_r;
      cyc("rnd", ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), p,
          busy_r, lk_r, 3'($urandom_range(1, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
